// File: rtl/booth_operand_dispatcher.sv
// Operand-pair FIFO and issue/collect sequencer for the 8-bit Booth FSMD multiplier.
// One multiplication in flight at a time; products leave in push order over valid/ready.
module booth_operand_dispatcher #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [7:0]                    in_multiplicand_i,
    input  logic [7:0]                    in_multiplier_i,
    output logic                          mul_enable_o,
    output logic [7:0]                    mul_multiplicand_o,
    output logic [7:0]                    mul_multiplier_o,
    input  logic                          mul_data_valid_i,
    input  logic [15:0]                   mul_product_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [15:0]                   out_product_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          err_timeout_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE   = {{(TW - 1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_ZERO  = {TW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [15:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_s;
    logic            push_s;
    logic            pop_s;
    logic            capture_s;
    logic [TW-1:0]   tmo_cnt_r;
    logic            err_r;
    logic            enable_r;
    logic            busy_r;
    logic [7:0]      mcand_r;
    logic [7:0]      mplier_r;
    logic            out_valid_r;
    logic [15:0]     out_product_r;

    assign in_ready_o         = (count_r != CNT_FULL);
    assign push_s             = in_valid_i & in_ready_o;
    assign fifo_count_o       = count_r;
    assign mul_enable_o       = enable_r;
    assign mul_multiplicand_o = mcand_r;
    assign mul_multiplier_o   = mplier_r;
    assign out_valid_o        = out_valid_r;
    assign out_product_o      = out_product_r;
    assign busy_o             = busy_r;
    assign err_timeout_o      = err_r;

    // Sequencer next state plus the pop and capture strobes it owns.
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|count_r) begin
                    pop_s   = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                // A full output slot stalls us here; the multiplier parks in FINISH meanwhile.
                if (mul_data_valid_i && (!out_valid_r || out_ready_i)) begin
                    capture_s = 1'b1;
                    state_s   = ST_RELEASE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RELEASE: state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // FIFO payload storage; contents are meaningless outside the valid window so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_multiplicand_i, in_multiplier_i};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
        end
    end

    // State register with registered enable pulse and busy flag derived from next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r  <= ST_IDLE;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            enable_r <= (state_s == ST_ISSUE) || (state_s == ST_RELEASE);
            busy_r   <= (state_s != ST_IDLE) || (|count_s);
        end
    end

    // Operand registers load only on a pop, so they stay stable from ISSUE through RELEASE.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mcand_r  <= 8'd0;
            mplier_r <= 8'd0;
        end else if (pop_s) begin
            {mcand_r, mplier_r} <= mem_r[rd_ptr_r];
        end
    end

    // Saturating WAIT watchdog and sticky timeout flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tmo_cnt_r <= TMO_ZERO;
            err_r     <= 1'b0;
        end else if (state_r == ST_ISSUE) begin
            tmo_cnt_r <= TMO_ZERO;
        end else if ((state_r == ST_WAIT) && !mul_data_valid_i && (tmo_cnt_r != TMO_MAX)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
            if (tmo_cnt_r == TMO_LAST) begin
                err_r <= 1'b1;
            end
        end
    end

    // Output slot: a capture wins over an accept in the same cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_valid_r   <= 1'b0;
            out_product_r <= 16'd0;
        end else if (capture_s) begin
            out_valid_r   <= 1'b1;
            out_product_r <= mul_product_i;
        end else if (out_ready_i) begin
            out_valid_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_operand_dispatcher.sv
// Randomised self-checking bench: behavioural Booth multiplier (17-cycle latency) and
// an in-order product scoreboard computed with plain integer arithmetic.
module tb_booth_operand_dispatcher;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  in_multiplicand_i = 8'd0;
    logic [7:0]  in_multiplier_i = 8'd0;
    logic        mul_enable_o;
    logic [7:0]  mul_multiplicand_o;
    logic [7:0]  mul_multiplier_o;
    logic        mul_data_valid_i;
    logic [15:0] mul_product_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] out_product_o;
    logic        busy_o;
    logic [2:0]  fifo_count_o;
    logic        err_timeout_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic        never_valid = 1'b0;

    // multiplier model state: 0 START, 1 busy, 2 FINISH
    int          m_state;
    int          m_cnt;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [15:0] m_prod;

    always #5 clk_i = ~clk_i;

    booth_operand_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_multiplicand_i(in_multiplicand_i), .in_multiplier_i(in_multiplier_i),
        .mul_enable_o(mul_enable_o), .mul_multiplicand_o(mul_multiplicand_o),
        .mul_multiplier_o(mul_multiplier_o), .mul_data_valid_i(mul_data_valid_i),
        .mul_product_i(mul_product_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_product_o(out_product_o),
        .busy_o(busy_o), .fifo_count_o(fifo_count_o), .err_timeout_o(err_timeout_o)
    );

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 16'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    assign mul_data_valid_i = (m_state == 2) && !never_valid;
    assign mul_product_i    = m_prod;

    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_prod  <= 16'd0;
            m_a     <= 8'd0;
            m_b     <= 8'd0;
        end else begin
            case (m_state)
                0: if (mul_enable_o) begin
                    m_state <= 1;
                    m_cnt   <= 1;
                    m_a     <= mul_multiplicand_o;
                    m_b     <= mul_multiplier_o;
                    m_prod  <= ref_prod(mul_multiplicand_o, mul_multiplier_o);
                end
                1: if (m_cnt == 16) m_state <= 2; else m_cnt <= m_cnt + 1;
                2: if (mul_enable_o) m_state <= 0;
                default: m_state <= 0;
            endcase
        end
    end

    // Scoreboard and multiplier-protocol monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (out_valid_o && out_ready_i) begin
                chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("product", 32'(out_product_o), 32'(exp_q.pop_front()));
            end
            if (m_state != 0) begin
                chk("opnd_a_hold", 32'(mul_multiplicand_o), 32'(m_a));
                chk("opnd_b_hold", 32'(mul_multiplier_o), 32'(m_b));
            end
            if (m_state == 1) chk("enable_while_busy", 32'(mul_enable_o), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int g = 0;
        while (!in_ready_o && g < 300) begin
            tick();
            g++;
        end
        chk("push_ready", 32'(in_ready_o), 32'd1);
        in_valid_i        = 1'b1;
        in_multiplicand_i = a;
        in_multiplier_i   = b;
        exp_q.push_back(ref_prod(a, b));
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid_o || busy_o) && g < 3000) begin
            tick();
            g++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic wait_release();
        int g = 0;
        @(negedge clk_i);
        while (!(mul_enable_o && out_valid_o) && g < 300) begin
            @(negedge clk_i);
            g++;
        end
        chk("release_seen", 32'(mul_enable_o && out_valid_o), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        chk({tag, "_enable"}, 32'(mul_enable_o), 32'd0);
        chk({tag, "_opnds"}, 32'({mul_multiplicand_o, mul_multiplier_o}), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_out_product"}, 32'(out_product_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count_o), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        int          en_cnt;
        int          g;
        int          sent;

        repeat (3) tick();
        chk_reset_outputs("reset");
        reset_ni = 1'b1;
        tick();

        // single op (7, -3): enable in cycle 2 and again in RELEASE
        push(8'd7, 8'hFD);
        @(negedge clk_i);
        chk("single_en_c1", 32'(mul_enable_o), 32'd0);
        @(negedge clk_i);
        chk("single_en_issue", 32'(mul_enable_o), 32'd1);
        g = 0;
        while (!out_valid_o && g < 100) begin
            @(negedge clk_i);
            g++;
        end
        chk("single_product", 32'(out_product_o), 32'h0000FFEB);
        chk("single_en_release", 32'(mul_enable_o), 32'd1);
        repeat (3) tick();
        chk("single_count", 32'(fifo_count_o), 32'd0);
        chk("single_busy", 32'(busy_o), 32'd0);

        // fill past depth: four pending behind one popped
        push(8'h80, 8'h80);
        push(8'h7F, 8'h7F);
        push(8'h80, 8'h7F);
        push(8'h00, 8'd55);
        push(8'hFF, 8'hFF);
        chk("fill_ready_low", 32'(in_ready_o), 32'd0);
        chk("fill_count", 32'(fifo_count_o), 32'd4);
        drain();

        // backpressure: second op must stall in WAIT
        out_ready_i = 1'b0;
        push(8'($urandom), 8'($urandom));
        push(8'($urandom), 8'($urandom));
        g = 0;
        while (!out_valid_o && g < 100) begin
            @(negedge clk_i);
            g++;
        end
        held = out_product_o;
        repeat (3) @(negedge clk_i);
        en_cnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (mul_enable_o) en_cnt++;
        end
        chk("bp_hold", 32'(out_product_o), 32'(held));
        chk("bp_valid", 32'(out_valid_o), 32'd1);
        chk("bp_no_release", 32'(en_cnt), 32'd0);
        chk("bp_busy", 32'(busy_o), 32'd1);
        tick();
        out_ready_i = 1'b1;
        drain();

        // timeout: valid withheld, flag after 64 WAIT cycles, late valid completes
        never_valid = 1'b1;
        push(8'($urandom), 8'($urandom));
        g = 0;
        @(negedge clk_i);
        while (!mul_enable_o && g < 50) begin
            @(negedge clk_i);
            g++;
        end
        repeat (60) @(negedge clk_i);
        chk("tmo_early", 32'(err_timeout_o), 32'd0);
        repeat (10) @(negedge clk_i);
        chk("tmo_set", 32'(err_timeout_o), 32'd1);
        never_valid = 1'b0;
        drain();
        chk("tmo_sticky", 32'(err_timeout_o), 32'd1);

        // reset mid-WAIT with two entries queued
        push(8'($urandom), 8'($urandom));
        push(8'($urandom), 8'($urandom));
        push(8'($urandom), 8'($urandom));
        repeat (8) tick();
        chk("rst_pre_count", 32'(fifo_count_o), 32'd2);
        reset_ni = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        exp_q.delete();
        repeat (3) tick();
        reset_ni = 1'b1;
        repeat (40) tick();
        chk("rst_no_stale", 32'(out_valid_o), 32'd0);
        chk("rst_idle", 32'(busy_o), 32'd0);

        // simultaneous push/pop at count 2 across pointer wrap
        push(8'($urandom), 8'($urandom));
        push(8'($urandom), 8'($urandom));
        push(8'($urandom), 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            wait_release();
            tick();
            chk("sp_pre_count", 32'(fifo_count_o), 32'd2);
            push(8'($urandom), 8'($urandom));
            chk("sp_post_count", 32'(fifo_count_o), 32'd2);
        end
        drain();

        // random traffic with random backpressure
        sent = 0;
        for (int c = 0; c < 700; c++) begin
            out_ready_i = 1'($urandom_range(0, 1));
            if (sent < 25 && in_ready_o && $urandom_range(0, 2) == 0) begin
                in_valid_i        = 1'b1;
                in_multiplicand_i = 8'($urandom);
                in_multiplier_i   = 8'($urandom);
                exp_q.push_back(ref_prod(in_multiplicand_i, in_multiplier_i));
                sent++;
            end else begin
                in_valid_i = 1'b0;
            end
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
